// File: rtl/register_bank_sequencer_pkg.sv
// Shared definitions for the register bank sequencer.
// Holds the operation codes, the FSM state encoding, the default data and
// selector widths, and small helpers that decode a raw op field and pick
// the first state of an accepted operation.
package register_bank_sequencer_pkg;

  localparam int RBS_DATA_W = 8;
  localparam int RBS_SEL_W  = 3;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LDI  = 2'b01,
    OP_MOV  = 2'b10,
    OP_SWAP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_B = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Anything that is not a clean known code (including X/Z bits) falls
  // through to NOP so a garbage op never touches the bank.
  function automatic op_e decode_op(input logic [1:0] raw);
    op_e res;
    case (raw)
      2'b01:   res = OP_LDI;
      2'b10:   res = OP_MOV;
      2'b11:   res = OP_SWAP;
      default: res = OP_NOP;
    endcase
    return res;
  endfunction

  // NOP skips straight to the completion pulse, LDI needs no read phase,
  // MOV and SWAP both begin by reading a register onto the bus.
  function automatic state_e first_state(input op_e op);
    state_e res;
    case (op)
      OP_LDI:  res = ST_WR_A;
      OP_MOV:  res = ST_RD_A;
      OP_SWAP: res = ST_RD_A;
      default: res = ST_DONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/register_bank_sequencer.sv
// register_bank_sequencer
// Sole master of the 8x8 register bank. Accepts one register-transfer op
// (NOP, LDI, MOV, SWAP) per start pulse in IDLE, sequences the bank's read
// and write strobes over several cycles and pulses done once at the end.
//
// Ports
//   clk, rst           clock and synchronous active-high reset
//   start              request, only looked at in IDLE
//   op, dst, src, imm  operation and operands, latched on the accept edge
//   busy               high while an op is in progress (not in DONE)
//   done               one-cycle completion pulse
//   rb_read_en         bank read strobe (bank drives bus from ry)
//   rb_write_en        bank write strobe (bank writes in_data to rx)
//   rb_rx_selector     bank write target
//   rb_ry_selector     bank read source
//   rb_in_data         bank write data
//   rb_bus_data        bank bus output, valid while rb_read_en is high
//
// Every output comes from a flop. The output flops are loaded from the
// value the FSM is about to enter, so each strobe is already stable for
// the whole cycle of the state it belongs to.
module register_bank_sequencer #(
  parameter int DATA_W = register_bank_sequencer_pkg::RBS_DATA_W,
  parameter int SEL_W  = register_bank_sequencer_pkg::RBS_SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [SEL_W-1:0]  dst,
  input  logic [SEL_W-1:0]  src,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  output logic              rb_read_en,
  output logic              rb_write_en,
  output logic [SEL_W-1:0]  rb_rx_selector,
  output logic [SEL_W-1:0]  rb_ry_selector,
  output logic [DATA_W-1:0] rb_in_data,
  input  logic [DATA_W-1:0] rb_bus_data
);

  import register_bank_sequencer_pkg::*;

  state_e state, state_next;

  op_e               op_q;
  logic [SEL_W-1:0]  dst_q, src_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] tmp_a;

  op_e               cur_op;
  logic [SEL_W-1:0]  cur_dst, cur_src;
  logic [DATA_W-1:0] cur_imm;

  logic              busy_next, done_next;
  logic              read_en_next, write_en_next;
  logic [SEL_W-1:0]  rx_next, ry_next;
  logic [DATA_W-1:0] in_data_next;

  // In IDLE the operands have not been latched yet, so the outputs for the
  // first state of a new op are built from the live inputs; afterwards the
  // latched copies are used and input changes no longer matter.
  always_comb begin
    cur_op  = op_q;
    cur_dst = dst_q;
    cur_src = src_q;
    cur_imm = imm_q;
    if (state == ST_IDLE) begin
      cur_op  = decode_op(op);
      cur_dst = dst;
      cur_src = src;
      cur_imm = imm;
    end
  end

  // Next-state logic. SWAP is the only op that uses the second read and the
  // second write; everything else funnels into DONE and then back to IDLE.
  // A start seen while in DONE is deliberately dropped.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = first_state(cur_op);
      ST_RD_A: state_next = (op_q == OP_SWAP) ? ST_RD_B : ST_WR_A;
      ST_RD_B: state_next = ST_WR_A;
      ST_WR_A: state_next = (op_q == OP_SWAP) ? ST_WR_B : ST_DONE;
      ST_WR_B: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output values for the state being entered. WR_A is entered either from
  // IDLE (LDI, immediate) or straight after a read cycle (MOV from RD_A,
  // SWAP from RD_B); in the read case the value the bank is driving right
  // now is the value to write, so it goes straight into the write-data flop
  // instead of via an extra holding register. WR_B writes back the first
  // register read of a SWAP, kept in tmp_a.
  always_comb begin
    busy_next     = 1'b0;
    done_next     = 1'b0;
    read_en_next  = 1'b0;
    write_en_next = 1'b0;
    rx_next       = '0;
    ry_next       = '0;
    in_data_next  = '0;
    case (state_next)
      ST_RD_A: begin
        busy_next    = 1'b1;
        read_en_next = 1'b1;
        ry_next      = (cur_op == OP_SWAP) ? cur_dst : cur_src;
      end
      ST_RD_B: begin
        busy_next    = 1'b1;
        read_en_next = 1'b1;
        ry_next      = cur_src;
      end
      ST_WR_A: begin
        busy_next     = 1'b1;
        write_en_next = 1'b1;
        rx_next       = cur_dst;
        in_data_next  = (cur_op == OP_LDI) ? cur_imm : rb_bus_data;
      end
      ST_WR_B: begin
        busy_next     = 1'b1;
        write_en_next = 1'b1;
        rx_next       = cur_src;
        in_data_next  = tmp_a;
      end
      ST_DONE: begin
        done_next = 1'b1;
      end
      default: begin
        busy_next = 1'b0;
      end
    endcase
  end

  // State, operand latches, bus capture and output flops. A reset in the
  // middle of an op simply returns everything to idle values; any write
  // already performed by a partial SWAP stays in the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      op_q           <= OP_NOP;
      dst_q          <= '0;
      src_q          <= '0;
      imm_q          <= '0;
      tmp_a          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      rb_read_en     <= 1'b0;
      rb_write_en    <= 1'b0;
      rb_rx_selector <= '0;
      rb_ry_selector <= '0;
      rb_in_data     <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && start) begin
        op_q  <= cur_op;
        dst_q <= dst;
        src_q <= src;
        imm_q <= imm;
      end
      if (state == ST_RD_A) begin
        tmp_a <= rb_bus_data;
      end
      busy           <= busy_next;
      done           <= done_next;
      rb_read_en     <= read_en_next;
      rb_write_en    <= write_en_next;
      rb_rx_selector <= rx_next;
      rb_ry_selector <= ry_next;
      rb_in_data     <= in_data_next;
    end
  end

endmodule
